// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: writeback state encoding and default widths.
package cpu_pkg;

  localparam int unsigned WB_WIDTH   = 32;
  localparam int unsigned WB_NSRC    = 4;
  localparam int unsigned WB_MEM_IDX = 2;
  localparam int unsigned RADDR_W    = 5;

  typedef enum logic [1:0] {
    WB_EMPTY = 2'd0,
    WB_WAIT  = 2'd1,
    WB_FULL  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/prio_sel_idx.sv
// Lowest-set-bit encoder; returns NSRC-1 when no select bit is set.
module prio_sel_idx #(
  parameter int unsigned NSRC  = 4,
  parameter int unsigned IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic [NSRC-1:0]  sel_i,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from the top so the lowest set index is written last.
  always_comb begin
    idx_o = IDX_W'(NSRC - 1);
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (sel_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/wb_select_pipe.sv
// Writeback source selector with a deferred load path and a backpressured
// output register feeding the integer register-file write port.
module wb_select_pipe #(
  parameter int unsigned WIDTH   = cpu_pkg::WB_WIDTH,
  parameter int unsigned NSRC    = cpu_pkg::WB_NSRC,
  parameter int unsigned MEM_IDX = cpu_pkg::WB_MEM_IDX,
  parameter int unsigned RADDR_W = cpu_pkg::RADDR_W,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NSRC*WIDTH-1:0]   src_data,
  input  logic [NSRC-1:0]         src_sel,
  input  logic [RADDR_W-1:0]      in_addr,
  input  logic                    in_we,
  input  logic [WIDTH-1:0]        mem_data,
  input  logic                    mem_valid,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [WIDTH-1:0]        wb_data,
  output logic [RADDR_W-1:0]      wb_addr,
  output logic                    wb_we,
  output logic                    err_timeout,
  output logic                    mem_unexp
);
  import cpu_pkg::*;

  localparam int unsigned SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  wb_state_e          state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [RADDR_W-1:0] addr_q, addr_d;
  logic               we_q, we_d;
  logic               err_q, err_d;
  logic               unexp_q, unexp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [SEL_W-1:0]   sel_idx;
  logic [WIDTH-1:0]   src_arr [NSRC];
  logic               sel_mem, direct, accept;
  logic [WIDTH-1:0]   sel_data;

  prio_sel_idx #(.NSRC(NSRC), .IDX_W(SEL_W)) u_prio (
    .sel_i (src_sel),
    .idx_o (sel_idx)
  );

  for (genvar g = 0; g < int'(NSRC); g++) begin : g_src
    assign src_arr[g] = src_data[g*WIDTH +: WIDTH];
  end

  assign sel_mem  = (sel_idx == SEL_W'(MEM_IDX));
  assign direct   = !sel_mem || mem_valid;
  assign sel_data = sel_mem ? mem_data : src_arr[sel_idx];
  assign in_ready = (state_q == WB_EMPTY) || ((state_q == WB_FULL) && wb_ready);
  assign accept   = in_valid && in_ready;

  // Next-state and output-register logic.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    addr_d  = addr_q;
    we_d    = we_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    // Load data outside WAIT is dropped unless a same-cycle accept consumes it.
    unexp_d = mem_valid && (state_q != WB_WAIT) && !(accept && sel_mem);
    unique case (state_q)
      WB_EMPTY, WB_FULL: begin
        if (accept) begin
          addr_d = in_addr;
          we_d   = in_we;
          if (direct) begin
            state_d = WB_FULL;
            data_d  = sel_data;
          end else begin
            state_d = WB_WAIT;
            cnt_d   = '0;
          end
        end else if ((state_q == WB_FULL) && wb_ready) begin
          state_d = WB_EMPTY;
        end
      end
      WB_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_valid) begin
          state_d = WB_FULL;
          data_d  = mem_data;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = WB_FULL;
          data_d  = '0;
          we_d    = 1'b0;
          err_d   = 1'b1;
        end
      end
      default: state_d = WB_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WB_EMPTY;
      data_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      unexp_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      err_q   <= err_d;
      unexp_q <= unexp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb_valid    = (state_q == WB_FULL);
  assign wb_data     = data_q;
  assign wb_addr     = addr_q;
  assign wb_we       = we_q;
  assign err_timeout = err_q;
  assign mem_unexp   = unexp_q;

endmodule

// File: tb/tb_wb_select_pipe.sv
// Self-checking bench for wb_select_pipe: vector table, corner sequences and
// a randomized run against a transaction-level scoreboard.
module tb_wb_select_pipe;

  localparam int W = 32;
  localparam int N = 4;
  localparam int MI = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid, in_ready;
  logic [N*W-1:0] src_data;
  logic [N-1:0]   src_sel;
  logic [4:0]     in_addr;
  logic           in_we;
  logic [W-1:0]   mem_data;
  logic           mem_valid;
  logic           wb_valid, wb_ready;
  logic [W-1:0]   wb_data;
  logic [4:0]     wb_addr;
  logic           wb_we, err_timeout, mem_unexp;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_select_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .src_data(src_data), .src_sel(src_sel), .in_addr(in_addr), .in_we(in_we),
    .mem_data(mem_data), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_data(wb_data), .wb_addr(wb_addr), .wb_we(wb_we),
    .err_timeout(err_timeout), .mem_unexp(mem_unexp)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_idx(input logic [N-1:0] s);
    for (int i = 0; i < N; i++) if (s[i]) return i;
    return N - 1;
  endfunction

  typedef struct {
    logic [N-1:0]   sel;
    logic [N*W-1:0] src;
    logic [4:0]     addr;
    logic           we;
    logic           mv;
    logic [W-1:0]   md;
    logic [W-1:0]   exp;
  } vec_t;

  vec_t vecs[7];

  typedef struct {
    logic [W-1:0] data;
    logic [4:0]   addr;
    logic         we;
  } res_t;

  res_t q[$];
  logic [W-1:0] got[$];

  initial begin
    logic [W-1:0] held;
    logic [W-1:0] nxt;
    logic exp_unexp, acc, exp_rdy;
    int idx;
    res_t r, e;

    rst_n = 1'b0; in_valid = 0; src_data = '0; src_sel = '0; in_addr = '0;
    in_we = 0; mem_data = '0; mem_valid = 0; wb_ready = 1;
    repeat (3) @(posedge clk);
    #3;
    chk("reset_wb_valid", wb_valid, 0);
    chk("reset_wb_data", wb_data, 0);
    chk("reset_err", err_timeout, 0);
    chk("reset_unexp", mem_unexp, 0);
    chk("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    vecs[0] = '{4'b0110, {32'h4, 32'h3, 32'h1111_0001, 32'h1}, 5'd3, 1, 0, 32'h0, 32'h1111_0001};
    vecs[1] = '{4'b0000, {32'hDEAD_BEEF, 32'h3, 32'h2, 32'h1}, 5'd9, 1, 0, 32'h0, 32'hDEAD_BEEF};
    vecs[2] = '{4'b0001, {32'h4, 32'h3, 32'h2, 32'hAAAA_0000}, 5'd31, 0, 0, 32'h0, 32'hAAAA_0000};
    vecs[3] = '{4'b1000, {32'h5555_1234, 32'h3, 32'h2, 32'h1}, 5'd1, 1, 0, 32'h0, 32'h5555_1234};
    vecs[4] = '{4'b0100, {32'h4, 32'hBAD0_BAD0, 32'h2, 32'h1}, 5'd17, 1, 1, 32'hCAFE_0001, 32'hCAFE_0001};
    vecs[5] = '{4'b1100, {32'h4, 32'h3, 32'h2, 32'h1}, 5'd4, 0, 1, 32'h1234_5678, 32'h1234_5678};
    vecs[6] = '{4'b1111, {32'h4, 32'h3, 32'h2, 32'h0F0F_0F0F}, 5'd12, 1, 0, 32'h0, 32'h0F0F_0F0F};

    foreach (vecs[k]) begin
      src_sel = vecs[k].sel; src_data = vecs[k].src; in_addr = vecs[k].addr;
      in_we = vecs[k].we; mem_valid = vecs[k].mv; mem_data = vecs[k].md;
      in_valid = 1; wb_ready = 1;
      #1;
      chk($sformatf("vec%0d_in_ready", k), in_ready, 1);
      tick();
      in_valid = 0; mem_valid = 0;
      chk($sformatf("vec%0d_valid", k), wb_valid, 1);
      chk($sformatf("vec%0d_data", k), wb_data, vecs[k].exp);
      chk($sformatf("vec%0d_addr", k), wb_addr, vecs[k].addr);
      chk($sformatf("vec%0d_we", k), wb_we, vecs[k].we);
      tick();
      chk($sformatf("vec%0d_drain", k), wb_valid, 0);
      chk($sformatf("vec%0d_unexp", k), mem_unexp, 0);
    end

    // Deferred load arriving on the third waiting cycle.
    src_sel = 4'b0100; in_addr = 5'd7; in_we = 1; in_valid = 1; mem_valid = 0;
    tick();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("defer_in_ready%0d", i), in_ready, 0);
      chk($sformatf("defer_valid%0d", i), wb_valid, 0);
      if (i == 2) begin mem_valid = 1; mem_data = 32'hA5; end
      tick();
    end
    mem_valid = 0;
    chk("defer_valid", wb_valid, 1);
    chk("defer_data", wb_data, 32'hA5);
    chk("defer_addr", wb_addr, 7);
    chk("defer_we", wb_we, 1);
    chk("defer_err", err_timeout, 0);
    chk("defer_unexp", mem_unexp, 0);
    tick();

    // Load that never arrives.
    src_sel = 4'b0100; in_addr = 5'd11; in_we = 1; in_valid = 1;
    tick();
    in_valid = 0;
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("to_wait%0d", i), wb_valid, 0);
      tick();
    end
    chk("to_valid", wb_valid, 1);
    chk("to_data", wb_data, 0);
    chk("to_we", wb_we, 0);
    chk("to_err", err_timeout, 1);
    tick();
    tick();
    chk("to_err_sticky", err_timeout, 1);
    chk("to_empty", wb_valid, 0);

    // Streaming 1..4 with a two-cycle stall.
    nxt = 1;
    got.delete();
    src_sel = 4'b0001; in_we = 1;
    for (int c = 0; c < 20; c++) begin
      wb_ready = !(c == 2 || c == 3);
      in_valid = (nxt <= 4);
      src_data = '0; src_data[W-1:0] = nxt; in_addr = nxt[4:0];
      #1;
      if (c == 2) held = wb_data;
      if (c == 3) chk("stall_hold", wb_data, held);
      if (c == 2 || c == 3) chk($sformatf("stall_in_ready%0d", c), in_ready, 0);
      if (wb_valid && wb_ready) got.push_back(wb_data);
      if (in_valid && in_ready) nxt++;
      tick();
    end
    in_valid = 0; wb_ready = 1;
    chk("stream_count", got.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("stream_res%0d", i), (i < got.size()) ? got[i] : 32'hX, i + 1);
    tick();

    // Async reset while waiting, then a stray load pulse.
    src_sel = 4'b0100; in_valid = 1; mem_valid = 0;
    tick();
    in_valid = 0;
    #2;
    rst_n = 0;
    #1;
    chk("rst_wait_valid", wb_valid, 0);
    chk("rst_wait_ready", in_ready, 1);
    chk("rst_err_clear", err_timeout, 0);
    #3;
    rst_n = 1;
    tick();
    mem_valid = 1; mem_data = 32'h77;
    tick();
    mem_valid = 0;
    chk("stray_unexp", mem_unexp, 1);
    chk("stray_valid", wb_valid, 0);
    tick();
    chk("stray_unexp_pulse", mem_unexp, 0);

    // Randomized run against a one-entry transaction scoreboard.
    q.delete();
    exp_unexp = 0;
    for (int c = 0; c < 400; c++) begin
      chk("rnd_unexp", mem_unexp, exp_unexp);
      in_valid = ($urandom % 4) != 0;
      src_sel = N'($urandom);
      for (int s = 0; s < N; s++) src_data[s*W +: W] = $urandom;
      in_addr = 5'($urandom); in_we = 1'($urandom);
      mem_data = $urandom;
      idx = ref_idx(src_sel);
      mem_valid = (idx == MI) ? 1'b1 : (($urandom % 6) == 0);
      wb_ready = ($urandom % 4) != 0;
      #1;
      exp_rdy = (q.size() == 0) || wb_ready;
      chk("rnd_in_ready", in_ready, exp_rdy);
      chk("rnd_valid", wb_valid, q.size() != 0);
      if (wb_valid && wb_ready && q.size() != 0) begin
        e = q.pop_front();
        chk("rnd_data", wb_data, e.data);
        chk("rnd_addr", wb_addr, e.addr);
        chk("rnd_we", wb_we, e.we);
      end
      acc = in_valid && exp_rdy;
      if (acc) begin
        r.data = (idx == MI) ? mem_data : src_data[idx*W +: W];
        r.addr = in_addr; r.we = in_we;
        q.push_back(r);
      end
      exp_unexp = mem_valid && !(acc && idx == MI);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_select_pipe.md
Name: wb_select_pipe

Overview:
- Writeback-stage source selector with a registered output and a valid/ready handshake.
- Generalises the fixed 4-way writeback data mux to NSRC priority-selected sources of parametrised width.
- Adds a deferred memory-load path (waits for late load data, with a timeout) and a backpressured output register.
- Sits between the execute/memory stage and the integer register-file write port.

Parameters:
WIDTH, 32, data width of every source and of the writeback data
NSRC, 4, number of data sources; index NSRC-1 is the default source used when no select bit is set
MEM_IDX, 2, index of the source whose data arrives later on mem_data/mem_valid; src_data slice MEM_IDX is ignored
RADDR_W, 5, destination register address width
TIMEOUT, 15, maximum cycles spent in WAIT_MEM before abort (minimum 1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream request valid
in_ready  out  1  block accepts a request this cycle
src_data  in  NSRC*WIDTH  source i occupies bits [i*WIDTH +: WIDTH]
src_sel  in  NSRC  select bits; the lowest set index wins
in_addr  in  RADDR_W  destination register
in_we  in  1  register write enable for this request
mem_data  in  WIDTH  late load data
mem_valid  in  1  mem_data valid; single-cycle pulse
wb_valid  out  1  output register holds a result
wb_ready  in  1  downstream consumes the result
wb_data  out  WIDTH  selected data
wb_addr  out  RADDR_W  destination register
wb_we  out  1  write enable (qualified by wb_valid)
err_timeout  out  1  sticky; set on a load timeout, cleared only by reset
mem_unexp  out  1  one-cycle pulse when mem_valid arrives outside WAIT_MEM

Behaviour:
- Reset: asynchronous, rst_n low. State goes to EMPTY. wb_valid, wb_data, wb_addr, wb_we, err_timeout, mem_unexp and the timeout counter all reset to 0.
- Selected index sel: lowest i with src_sel[i]=1; NSRC-1 when src_sel==0.
- Accept condition: accept = in_valid & in_ready.
- in_ready is combinational: 1 in EMPTY, equal to wb_ready in FULL, 0 in WAIT_MEM.
- On accept, the request completes directly ("direct") when sel!=MEM_IDX, or when sel==MEM_IDX and mem_valid=1 in the same cycle.
- States:
  - EMPTY:
    - accept & direct -> FULL. Load wb_data with src slice sel, or with mem_data when sel==MEM_IDX. Load wb_addr and wb_we.
    - accept & not direct -> WAIT_MEM. Latch in_addr and in_we into the output regs; set counter to 0.
  - WAIT_MEM:
    - wb_valid=0; counter increments each cycle.
    - mem_valid=1 -> FULL, wb_data=mem_data.
    - Otherwise, when counter==TIMEOUT-1 -> FULL with wb_data=0, wb_we=0, err_timeout=1.
    - mem_valid wins if it coincides with the timeout cycle.
  - FULL:
    - wb_valid=1.
    - wb_ready=1 & accept: reload exactly as from EMPTY (back-to-back, no bubble).
    - wb_ready=1 & no accept -> EMPTY.
    - wb_ready=0: all outputs hold stable.
- Latency: a direct request is visible on wb_* one cycle after accept. A deferred load is visible one cycle after mem_valid.
- Throughput: one result per cycle when nothing stalls.
- mem_unexp: pulses for one cycle when mem_valid=1 in EMPTY or FULL and that pulse is not consumed by a same-cycle direct accept. Such data is dropped.
- Writeback outputs change only on state-register updates; wb_* have no combinational path from inputs.

Decomposition:
- Shared package (cpu_pkg):
  - state encoding constants WB_EMPTY=2'd0, WB_WAIT=2'd1, WB_FULL=2'd2
  - default parameter values WB_WIDTH=32, WB_NSRC=4, WB_MEM_IDX=2, RADDR_W=5
- One natural sub-module: prio_sel_idx. It is a parametrised lowest-set-bit encoder with default index NSRC-1 and is reusable by the float writeback path.

Test Plan:
- Direct select: src_sel=4'b0110, src_data[1]=32'h1111_0001, in_addr=5'd3, we=1, wb_ready=1 -> next cycle wb_valid=1, wb_data=32'h1111_0001, wb_addr=3, wb_we=1.
- Default select: src_sel=0, src_data[3]=32'hDEAD_BEEF -> wb_data=32'hDEAD_BEEF.
- Deferred load: sel=MEM_IDX, mem_valid=0 at accept; mem_data=32'h0000_00A5 pulsed 3 cycles later -> in_ready=0 for those 3 cycles; wb_data=32'hA5 one cycle after the pulse; err_timeout=0.
- Timeout: sel=MEM_IDX with no mem_valid for 15 cycles -> wb_valid=1, wb_data=0, wb_we=0, err_timeout=1 and stays 1.
- Backpressure/streaming: 4 direct requests 1..4 with wb_ready low for 2 cycles mid-stream -> wb_data holds stable while stalled; in_ready=0 while stalled; results are 1,2,3,4 in order with no loss or duplicate.
- Reset mid-WAIT_MEM: assert rst_n=0 asynchronously -> wb_valid=0 and in_ready=1 immediately. A later mem_valid pulse -> mem_unexp=1 for one cycle.
